// File: rtl/sinegen_pkg.sv
// Shared types and default widths for the sine address generator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sinegen_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HOLD
  } addr_gen_state_t;

  localparam int ADDR_W = 8;
  localparam int FRAC_W = 8;

endpackage

// File: rtl/step_pending_reg.sv
// Single-entry holding buffer for a step update that arrives while running.
// Latency: push visible on pend_vld/pend_dat the cycle after push_vld.
// Backpressure: owner must only push while pend_vld=0; pop drains the entry.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset (discards entry)
//   push_vld, push_dat  load a new pending step
//   pop                 the owner has consumed the pending step
//   pend_vld, pend_dat  buffer occupancy and contents
module step_pending_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         pend_vld,
  output logic [W-1:0] pend_dat
);

  logic         pend_vld_q;
  logic [W-1:0] pend_dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_vld_q <= 1'b0;
      pend_dat_q <= '0;
    end else if (push_vld) begin
      pend_vld_q <= 1'b1;
      pend_dat_q <= push_dat;
    end else if (pop) begin
      pend_vld_q <= 1'b0;
    end
  end

  assign pend_vld = pend_vld_q;
  assign pend_dat = pend_dat_q;

endmodule

// File: rtl/sine_addr_gen.sv
// Phase-accumulator address generator driving both ports of a dual-port sine ROM.
// Latency: addr1/addr2/wrap/running registered, one cycle after the accumulator update.
// Backpressure: step_ready drops while a step update waits for the next cycle wrap.
//
// Optional build macro SINE_ADDR_GEN_WRAP_CNT_EN adds a 16-bit wrap_count output.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   en, clr           run/hold control; clr zeroes phase (step kept), beats en
//   step_in/_valid    requested phase increment with valid/ready handshake
//   step_ready        combinational ready for step_in
//   offset            phase offset added to addr2
//   addr1, addr2      aligned ROM addresses
//   wrap              one-cycle pulse on accumulator carry-out
//   running           FSM is in RUN
//   wrap_count        (optional) wrap pulse counter, cleared by rst/clr
module sine_addr_gen
  import sinegen_pkg::*;
#(
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int FRAC_WIDTH    = FRAC_W,
  parameter int ACC_WIDTH     = ADDRESS_WIDTH + FRAC_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [ACC_WIDTH-1:0]     step_in,
  input  logic                     step_valid,
  output logic                     step_ready,
  input  logic [ADDRESS_WIDTH-1:0] offset,
  output logic [ADDRESS_WIDTH-1:0] addr1,
  output logic [ADDRESS_WIDTH-1:0] addr2,
  output logic                     wrap,
  output logic                     running
`ifdef SINE_ADDR_GEN_WRAP_CNT_EN
  ,
  output logic [15:0]              wrap_count
`endif
);

  addr_gen_state_t          state_q, state_d;
  logic [ACC_WIDTH-1:0]     acc_q, acc_d;
  logic [ACC_WIDTH-1:0]     step_q, step_d;
  logic [ADDRESS_WIDTH-1:0] addr1_q, addr2_q, addr_next;
  logic                     wrap_q, running_q;
  logic [ACC_WIDTH:0]       sum;
  logic                     in_run, add, carry;
  logic                     pend_vld, push, pop;
  logic [ACC_WIDTH-1:0]     pend_dat;

  assign in_run = (state_q == RUN);
  assign add    = in_run & en & ~clr;
  assign sum    = {1'b0, acc_q} + {1'b0, step_q};
  assign carry  = add & sum[ACC_WIDTH];

  // Outside RUN a step is taken straight into step_q; inside RUN it is parked
  // until the next carry so the current waveform period finishes cleanly.
  assign step_ready = rst | ~in_run | ~pend_vld;
  assign push       = in_run & step_valid & ~pend_vld;
  assign pop        = pend_vld & (~in_run | carry);

  step_pending_reg #(.W(ACC_WIDTH)) u_pend (
    .clk      (clk),
    .rst      (rst),
    .push_vld (push),
    .push_dat (step_in),
    .pop      (pop),
    .pend_vld (pend_vld),
    .pend_dat (pend_dat)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    step_d  = step_q;

    if (!in_run) begin
      // A fresh handshake beats a leftover pending value.
      if (step_valid)    step_d = step_in;
      else if (pend_vld) step_d = pend_dat;
    end else if (carry && pend_vld) begin
      step_d = pend_dat;
    end

    if (clr)      acc_d = '0;
    else if (add) acc_d = sum[ACC_WIDTH-1:0];

    if (clr) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = en ? RUN : IDLE;
        RUN:     state_d = en ? RUN : HOLD;
        HOLD:    state_d = en ? RUN : HOLD;
        default: state_d = IDLE;
      endcase
    end
  end

  assign addr_next = acc_d[ACC_WIDTH-1:FRAC_WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      step_q    <= '0;
      addr1_q   <= '0;
      addr2_q   <= '0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      step_q    <= step_d;
      addr1_q   <= addr_next;
      addr2_q   <= addr_next + offset;
      wrap_q    <= carry;
      running_q <= (state_d == RUN);
    end
  end

  assign addr1   = addr1_q;
  assign addr2   = addr2_q;
  assign wrap    = wrap_q;
  assign running = running_q;

`ifdef SINE_ADDR_GEN_WRAP_CNT_EN
  // Counted alongside wrap_q so the count and the pulse appear together.
  logic [15:0] wrap_cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr)  wrap_cnt_q <= '0;
    else if (carry)  wrap_cnt_q <= wrap_cnt_q + 16'd1;
  end

  assign wrap_count = wrap_cnt_q;
`endif

endmodule

// File: tb/tb_sine_addr_gen.sv
// Self-checking bench for sine_addr_gen: directed scenarios plus random traffic
// compared cycle by cycle against a phase/step arithmetic model.
// Build with SINE_ADDR_GEN_WRAP_CNT_EN defined to also cover wrap_count.
module tb_sine_addr_gen;

  logic        clk = 1'b0;
  logic        rst, en, clr, step_valid, step_ready, wrap, running;
  logic [15:0] step_in;
  logic [7:0]  offset, addr1, addr2;
`ifdef SINE_ADDR_GEN_WRAP_CNT_EN
  logic [15:0] wrap_count;
`endif

  always #5 clk = ~clk;

  sine_addr_gen dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .step_in    (step_in),
    .step_valid (step_valid),
    .step_ready (step_ready),
    .offset     (offset),
    .addr1      (addr1),
    .addr2      (addr2),
    .wrap       (wrap),
    .running    (running)
`ifdef SINE_ADDR_GEN_WRAP_CNT_EN
    ,
    .wrap_count (wrap_count)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: phase in units of 1/65536 of a table cycle.
  // mode: 0 = idle, 1 = running, 2 = held.
  int m_phase, m_step, m_pend, m_pend_has, m_mode;
  int m_a1, m_a2, m_wrap, m_run, m_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int m_ready();
    return (rst || m_mode != 1 || !m_pend_has) ? 1 : 0;
  endfunction

  task automatic model_step();
    int rdy, took, adding, sum, carry;
    rdy = m_ready();
    if (rst) begin
      m_phase = 0; m_step = 0; m_pend = 0; m_pend_has = 0; m_mode = 0;
      m_a1 = 0; m_a2 = 0; m_wrap = 0; m_run = 0; m_cnt = 0;
    end else begin
      took   = (step_valid && rdy) ? 1 : 0;
      adding = (m_mode == 1 && en && !clr) ? 1 : 0;
      sum    = m_phase + m_step;
      carry  = (adding && sum >= 65536) ? 1 : 0;
      if (m_mode != 1) begin
        if (took) m_step = int'(step_in);
        else if (m_pend_has) m_step = m_pend;
        m_pend_has = 0;
      end else begin
        if (carry && m_pend_has) begin
          m_step = m_pend;
          m_pend_has = 0;
        end
        if (took) begin
          m_pend = int'(step_in);
          m_pend_has = 1;
        end
      end
      if (clr) m_phase = 0;
      else if (adding) m_phase = sum % 65536;
      if (clr) m_mode = 0;
      else if (en) m_mode = 1;
      else if (m_mode == 1) m_mode = 2;
      m_wrap = carry;
      m_cnt  = clr ? 0 : (m_cnt + carry) % 65536;
      m_a1   = m_phase / 256;
      m_a2   = (m_a1 + int'(offset)) % 256;
      m_run  = (m_mode == 1) ? 1 : 0;
    end
  endtask

  // One clock: ready checked mid-cycle, outputs checked just after the edge.
  task automatic tick();
    @(negedge clk);
    chk("step_ready", step_ready, m_ready());
    @(posedge clk);
    model_step();
    #1;
    chk("addr1", addr1, m_a1);
    chk("addr2", addr2, m_a2);
    chk("wrap", wrap, m_wrap);
    chk("running", running, m_run);
`ifdef SINE_ADDR_GEN_WRAP_CNT_EN
    chk("wrap_count", wrap_count, m_cnt);
`endif
  endtask

  int n;
  int seq180 [4] = '{1, 3, 4, 6};
  int pre;
  int a0;

  initial begin
    rst = 1; en = 0; clr = 0; step_valid = 0; step_in = '0; offset = '0;
    m_phase = 0; m_step = 0; m_pend = 0; m_pend_has = 0; m_mode = 0;
    m_a1 = 0; m_a2 = 0; m_wrap = 0; m_run = 0; m_cnt = 0;
    tick(); tick();
    rst = 0;
    tick();
    chk("rst_addr1", addr1, 0);
    chk("rst_addr2", addr2, 0);
    chk("rst_running", running, 0);

    // Unit step, offset 64: one address per cycle, wrap at 256.
    offset = 8'd64; step_in = 16'h0100; step_valid = 1;
    tick();
    step_valid = 0; en = 1;
    tick();
    chk("t1_running", running, 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("t1_seq", addr1, k);
      chk("t1_addr2", addr2, k + 64);
    end
    n = 5;
    while (!wrap && n < 300) begin tick(); n++; end
    chk("t1_wrap_cycle", n, 256);
    chk("t1_wrap_addr", addr1, 0);
    tick();
    chk("t1_wrap_once", wrap, 0);

    // Half step: new address every other cycle.
    en = 0; clr = 1; tick();
    clr = 0; step_in = 16'h0080; step_valid = 1; en = 1; tick();
    step_valid = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t2_half", addr1, (k * 128) / 256);
    end

    // 1.5 step.
    clr = 1; tick();
    clr = 0; step_in = 16'h0180; step_valid = 1; tick();
    step_valid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t2_onehalf", addr1, seq180[k]);
    end

    // Step change while running waits for the wrap.
    clr = 1; tick();
    clr = 0; step_in = 16'h0100; step_valid = 1; tick();
    step_valid = 0;
    repeat (10) tick();
    step_in = 16'h0200; step_valid = 1; tick();
    step_valid = 0;
    chk("t3_ready_low", step_ready, 0);
    tick();
    chk("t3_still_one", addr1, 12);
    n = 0;
    while (!wrap && n < 400) begin tick(); n++; end
    chk("t3_wrap_seen", wrap, 1);
    chk("t3_wrap_addr", addr1, 0);
    chk("t3_ready_back", step_ready, 1);
    tick(); chk("t3_by_two_a", addr1, 2);
    tick(); chk("t3_by_two_b", addr1, 4);

    // Hold at 100, move offset while held, resume.
    clr = 1; tick();
    clr = 0; step_in = 16'h0100; step_valid = 1; tick();
    step_valid = 0;
    n = 0;
    while (addr1 != 8'd100 && n < 300) begin tick(); n++; end
    chk("t4_at100", addr1, 100);
    en = 0; tick();
    chk("t4_hold_addr", addr1, 100);
    chk("t4_hold_running", running, 0);
    offset = 8'd10; tick();
    chk("t4_offset", addr2, 110);
    chk("t4_hold_addr2", addr1, 100);
    en = 1; tick();
    chk("t4_rerun", running, 1);
    tick();
    chk("t4_resume", addr1, 101);

    // clr with a step pending.
    repeat (5) tick();
    step_in = 16'h0300; step_valid = 1; tick();
    step_valid = 0; clr = 1; tick();
    clr = 0;
    chk("t5_clr_addr", addr1, 0);
    chk("t5_clr_ready", step_ready, 1);
    repeat (4) tick();
    // clr with no pending step keeps the current step.
    en = 0; tick();
    step_in = 16'h0100; step_valid = 1; tick();
    step_valid = 0; en = 1; tick();
    repeat (3) tick();
    clr = 1; tick();
    clr = 0;
    chk("t5_clr2_addr", addr1, 0);
    tick(); tick();
    chk("t5_step_kept", addr1, 1);

    // rst with a step pending: step and pending both discarded.
    repeat (3) tick();
    step_in = 16'h0500; step_valid = 1; tick();
    step_valid = 0; rst = 1; tick();
    chk("t5_rst_ready", step_ready, 1);
    rst = 0; tick();
    chk("t5_rst_addr", addr1, 0);
    chk("t5_rst_ready2", step_ready, 1);
    repeat (4) tick();
    chk("t5_zero_step", addr1, 0);
    chk("t5_zero_wrap", wrap, 0);

    // Half-cycle step: alternate 128/0 with wrap every second cycle.
    en = 0; tick();
    step_in = 16'h8000; step_valid = 1; tick();
    step_valid = 0; en = 1; tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t6_alt", addr1, (k % 2) ? 128 : 0);
      chk("t6_wrap", wrap, (k % 2) ? 0 : 1);
    end

`ifdef SINE_ADDR_GEN_WRAP_CNT_EN
    clr = 1; tick();
    clr = 0;
    chk("t7_cnt_clr", wrap_count, 0);
    tick();
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("t7_cnt", wrap_count, k / 2);
    end
    en = 0; tick();
    step_in = 16'hFFFF; step_valid = 1; tick();
    step_valid = 0; en = 1;
    n = 0; a0 = 0;
    while (a0 == 0 && n < 70000) begin
      pre = int'(wrap_count);
      tick();
      n++;
      if (pre == 16'hFFFF && wrap_count == 16'h0000) a0 = 1;
    end
    chk("t7_rollover", a0, 1);
`endif

    // Random traffic against the model.
    clr = 1; en = 0; tick();
    clr = 0;
    for (int i = 0; i < 3000; i++) begin
      rst    = ($urandom_range(0, 299) == 0);
      clr    = ($urandom_range(0, 49) == 0);
      en     = ($urandom_range(0, 9) < 8);
      if ($urandom_range(0, 15) == 0) offset = 8'($urandom);
      if (!step_valid && $urandom_range(0, 7) == 0) begin
        step_valid = 1;
        case ($urandom_range(0, 3))
          0:       step_in = 16'($urandom);
          1:       step_in = 16'h8000;
          2:       step_in = 16'h0000;
          default: step_in = 16'($urandom_range(1, 1024));
        endcase
      end
      pre = (step_valid && m_ready()) ? 1 : 0;
      tick();
      if (pre != 0) step_valid = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sine_addr_gen.md
Name: sine_addr_gen

Overview:
- Phase-accumulator address generator that sits directly upstream of the dual-port sine ROM and drives its two address inputs.
- A fixed-point step sets output frequency; a phase offset sets addr2 relative to addr1 (e.g. 64 = 90° on a 256-entry table).
- Step changes arrive over a valid/ready handshake and are applied only at a cycle wrap, so a running waveform never glitches mid-cycle.

Parameters:
- ADDRESS_WIDTH, 8, ROM address bits, the integer part of the accumulator.
- FRAC_WIDTH, 8, fractional accumulator bits.
- ACC_WIDTH, ADDRESS_WIDTH+FRAC_WIDTH, accumulator and step width (derived).

Ports:
- clk  input  1  single clock, all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  run (1) / hold (0).
- clr  input  1  synchronous clear of phase; step is kept.
- step_in  input  ACC_WIDTH  requested phase increment.
- step_valid  input  1  step_in valid.
- step_ready  output  1  step accepted when step_valid & step_ready.
- offset  input  ADDRESS_WIDTH  phase offset of addr2.
- addr1  output  ADDRESS_WIDTH  ROM port 1 address.
- addr2  output  ADDRESS_WIDTH  ROM port 2 address.
- wrap  output  1  one-cycle pulse when addr1 wraps.
- running  output  1  FSM is in RUN.

Behaviour:
- Reset: acc=0, step_reg=0, pend_valid=0, state=IDLE, addr1=0, addr2=0, wrap=0, running=0.
- step_ready is combinational and is 1 during reset/IDLE.
- FSM states:
  - IDLE: acc=0. en=1 -> RUN.
  - RUN: acc <= acc + step_reg, modulo 2^ACC_WIDTH. en=0 -> HOLD.
  - HOLD: acc frozen. en=1 -> RUN.
  - clr=1 in any state -> IDLE next cycle with acc=0. clr has priority over en.
  - rst has priority over everything, including mid-update; any pending step is discarded.
- Outputs (all registered; addr1 and addr2 are aligned):
  - addr1 <= next acc[ACC_WIDTH-1:FRAC_WIDTH].
  - addr2 <= (that value + offset) mod 2^ADDRESS_WIDTH.
  - offset is sampled every cycle, in every state.
  - wrap <= 1 for exactly the cycle in which the RUN addition produces a carry out of bit ACC_WIDTH-1; otherwise 0.
- Step handshake:
  - In IDLE/HOLD: step_ready=1. An accepted step loads step_reg next cycle.
  - In RUN: step_ready = !pend_valid. An accepted step goes to the pending register and sets pend_valid.
  - On a carry cycle with pend_valid=1: that cycle's addition uses the old step_reg; then step_reg <= pending and pend_valid <= 0.
  - Accept and carry in the same cycle with pend_valid=0: the value goes to pending and is applied at the next carry.
  - Entering HOLD/IDLE with pend_valid=1: pending is copied to step_reg on the first cycle in that state, and pend_valid clears.
  - With pend_valid=1 in RUN, step_ready=0; step_valid must hold its value until accepted.
- Arithmetic:
  - step_reg=0 in RUN keeps the output frozen, with wrap=0.
  - Step 2^(ACC_WIDTH-1) alternates addr1 between 0 and 128 and sets wrap every second cycle.

Optional Feature:
- Macro: SINE_ADDR_GEN_WRAP_CNT_EN.
- Defined: adds output wrap_count [15:0].
  - Reset to 0 by rst and by clr.
  - Increments on every wrap pulse, rolling over 0xFFFF -> 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Package sinegen_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, HOLD} addr_gen_state_t.
  - Default width constants: ADDR_W=8, FRAC_W=8.
- Sub-module step_pending_reg: the single-entry pending buffer with valid/ready, load-on-apply and pend_valid flag.
- The FSM, accumulator and output registers stay in sine_addr_gen.

Test Plan:
- Reset, then offset=64, step=0x0100, en=1: addr1 runs 1,2,3… one per cycle; addr2 = addr1+64 mod 256; wrap pulses when addr1 goes 255->0, 256 cycles after the first increment.
- Step=0x0080: addr1 advances every 2 cycles. Step=0x0180: addr1 sequence 1,3,4,6…
- While running with step=0x0100, send step 0x0200 mid-cycle: step_ready drops the next cycle; addr1 increments by 1 until the wrap, then by 2; step_ready returns to 1.
- en=0 at addr1=100: addr1 stays 100 and running=0. Change offset to 10 while held: addr2=110 one cycle later. en=1: resumes at 101.
- Apply clr and rst mid-run with a step pending: addr1=0 the next cycle. After clr the old step_reg is kept; after rst step_reg=0 and pending is discarded (check step_ready=1).
- SINE_ADDR_GEN_WRAP_CNT_EN defined, step=0x8000: wrap_count increments every 2 cycles; force the count past 0xFFFF and check rollover to 0.
